// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-bus definitions: responder FSM states and the default
// memory-mapped I/O address.
package lc3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SRAM_RD = 2'd1,
        SRAM_WR = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

endpackage

// File: rtl/reg_16.sv
// 16-bit holding register with load enable and asynchronous active-high clear.
module reg_16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] D_In,
    output logic [15:0] D_Out
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            D_Out <= '0;
        else if (Load)
            D_Out <= D_In;
    end

endmodule

// File: rtl/mem_io_responder.sv
// LC-3 memory-side responder: decodes MAR/MDR requests to board SRAM or the
// switch/hex I/O location and returns a one-cycle Mem_Ready on completion.
//
// Handshake: the requester raises Mem_Req with MAR/MDR/Mem_WE stable and holds it
// until Mem_Ready; the request is taken on the first rising edge seen in IDLE, and
// Mem_Ready pulses for exactly one cycle with MDR_In already valid for reads.
module mem_io_responder
    import lc3_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        Mem_Req,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MDR_In,
    output logic        Mem_Ready,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Data,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output mem_state_t  Dbg_State
);

    localparam int            CW       = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mem_state_t    state;
    logic [CW-1:0] cnt;

    logic          io_hit;
    logic          mdr_load;
    logic [15:0]   mdr_d;
    logic          hex_load;

    assign io_hit    = (MAR == IO_ADDR);
    assign Dbg_State = state;

    // Holding-register load strobes; they fire on the same edge the FSM leaves the state.
    always_comb begin
        mdr_load = 1'b0;
        mdr_d    = SRAM_DQ_IN;
        hex_load = 1'b0;
        if (state == IDLE && Mem_Req && io_hit) begin
            if (Mem_WE) begin
                hex_load = 1'b1;
            end else begin
                mdr_load = 1'b1;
                mdr_d    = Switches;
            end
        end else if (state == SRAM_RD && cnt == '0) begin
            mdr_load = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state       <= IDLE;
            cnt         <= '0;
            Mem_Ready   <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
        end else begin
            Mem_Ready  <= 1'b0;
            SRAM_DQ_OE <= 1'b0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            case (state)
                IDLE: begin
                    if (Mem_Req) begin
                        SRAM_ADDR   <= {4'h0, MAR};
                        SRAM_DQ_OUT <= MDR;
                        if (io_hit) begin
                            state     <= DONE;
                            Mem_Ready <= 1'b1;
                        end else if (Mem_WE) begin
                            state      <= SRAM_WR;
                            cnt        <= CNT_INIT;
                            SRAM_CE_N  <= 1'b0;
                            SRAM_DQ_OE <= 1'b1;
                            SRAM_WE_N  <= (CNT_INIT == '0);
                        end else begin
                            state     <= SRAM_RD;
                            cnt       <= CNT_INIT;
                            SRAM_CE_N <= 1'b0;
                            SRAM_OE_N <= 1'b0;
                        end
                    end
                end
                SRAM_RD: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        Mem_Ready <= 1'b1;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= 1'b0;
                    end
                end
                SRAM_WR: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        Mem_Ready <= 1'b1;
                    end else begin
                        // WE_N rises one cycle before CE_N/DQ_OE drop so data holds past it.
                        cnt        <= cnt - 1'b1;
                        SRAM_CE_N  <= 1'b0;
                        SRAM_DQ_OE <= 1'b1;
                        SRAM_WE_N  <= (cnt == CNT_ONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    reg_16 u_mdr_in_reg (
        .Clk   (Clk),
        .Reset (Reset_ah),
        .Load  (mdr_load),
        .D_In  (mdr_d),
        .D_Out (MDR_In)
    );

    reg_16 u_hex_reg (
        .Clk   (Clk),
        .Reset (Reset_ah),
        .Load  (hex_load),
        .D_In  (MDR),
        .D_Out (HEX_Data)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed accesses against a small SRAM model, with a
// scoreboard checking MDR_In and completion cycle whenever Mem_Ready is seen.
module tb_mem_io_responder;
    import lc3_pkg::*;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset_ah;
    logic        Mem_Req;
    logic        Mem_WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDR_In;
    logic        Mem_Ready;
    logic [15:0] Switches;
    logic [15:0] HEX_Data;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    mem_state_t  Dbg_State;

    mem_io_responder #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
        .Clk         (Clk),
        .Reset_ah    (Reset_ah),
        .Mem_Req     (Mem_Req),
        .Mem_WE      (Mem_WE),
        .MAR         (MAR),
        .MDR         (MDR),
        .MDR_In      (MDR_In),
        .Mem_Ready   (Mem_Ready),
        .Switches    (Switches),
        .HEX_Data    (HEX_Data),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .Dbg_State   (Dbg_State)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    logic [15:0] mem [0:255];
    assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N)
            mem[SRAM_ADDR[7:0]] = SRAM_DQ_OUT;
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int ready_cnt = 0;
    logic [15:0] exp_q[$];
    int          cyc_q[$];

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset_ah && Mem_Ready) begin
            logic [15:0] e;
            int          ec;
            ready_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ready: got Mem_Ready=1 at cycle %0d expected none", cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("mdr_in_at_ready", {4'h0, MDR_In}, {4'h0, e});
                check("ready_cycle", 20'(cyc), 20'(ec));
            end
        end
    end

    // ---------------- driver ----------------
    // lat counts the accept edge as cycle 1.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] data,
                             input logic [15:0] exp_rd, input int lat, input int exp_ce,
                             input int exp_oe, input int exp_wel, input int exp_drv);
        int   ce_lo, oe_lo, we_lo, drv;
        logic done, last_wen, last_dqoe;
        ce_lo = 0; oe_lo = 0; we_lo = 0; drv = 0;
        done = 1'b0; last_wen = 1'b1; last_dqoe = 1'b0;
        @(negedge Clk);
        Mem_Req = 1'b1;
        Mem_WE  = we;
        MAR     = addr;
        MDR     = data;
        exp_q.push_back(exp_rd);
        cyc_q.push_back(cyc + lat);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clk);
            if (!SRAM_CE_N) ce_lo++;
            if (!SRAM_OE_N) oe_lo++;
            if (!SRAM_WE_N) we_lo++;
            if (SRAM_DQ_OE && SRAM_DQ_OUT == data) drv++;
            if (Mem_Ready) begin
                done = 1'b1;
            end else begin
                last_wen  = SRAM_WE_N;
                last_dqoe = SRAM_DQ_OE;
            end
        end
        Mem_Req = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout addr %h: got no Mem_Ready expected one within 20 cycles", addr);
        end
        check("ce_low_cycles", 20'(ce_lo), 20'(exp_ce));
        check("oe_low_cycles", 20'(oe_lo), 20'(exp_oe));
        check("we_low_cycles", 20'(we_lo), 20'(exp_wel));
        check("dq_drive_cycles", 20'(drv), 20'(exp_drv));
        check("we_n_last_cycle", {19'h0, last_wen}, 20'h1);
        check("dq_oe_last_cycle", {19'h0, last_dqoe}, {19'h0, (exp_drv != 0)});
        @(negedge Clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int rc0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h30] = 16'h5A5A;
        Reset_ah = 1'b1;
        Mem_Req  = 1'b0;
        Mem_WE   = 1'b0;
        MAR      = 16'h0000;
        MDR      = 16'h0000;
        Switches = 16'h00A5;

        // reset state
        #2;
        check("rst_mdr_in", {4'h0, MDR_In}, 20'h0);
        check("rst_hex", {4'h0, HEX_Data}, 20'h0);
        check("rst_ready", {19'h0, Mem_Ready}, 20'h0);
        check("rst_addr", SRAM_ADDR, 20'h0);
        check("rst_dq_out", {4'h0, SRAM_DQ_OUT}, 20'h0);
        check("rst_dq_oe", {19'h0, SRAM_DQ_OE}, 20'h0);
        check("rst_strobes", {17'h0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 20'h7);
        check("rst_state", 20'(Dbg_State), 20'(IDLE));
        @(negedge Clk);
        Reset_ah = 1'b0;
        repeat (2) @(negedge Clk);

        // SRAM read
        do_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, W + 1, W, W, 0, 0);
        check("read_addr", SRAM_ADDR, 20'h00010);

        // reset during SRAM_RD
        @(negedge Clk);
        Mem_Req = 1'b1; Mem_WE = 1'b0; MAR = 16'h0040;
        @(posedge Clk);
        #1;
        check("pre_rst_state", 20'(Dbg_State), 20'(SRAM_RD));
        check("pre_rst_ce", {19'h0, SRAM_CE_N}, 20'h0);
        #2;
        Reset_ah = 1'b1;
        #1;
        check("mid_rst_ce_oe", {18'h0, SRAM_CE_N, SRAM_OE_N}, 20'h3);
        check("mid_rst_state", 20'(Dbg_State), 20'(IDLE));
        check("mid_rst_mdr_in", {4'h0, MDR_In}, 20'h0);
        check("mid_rst_ready", {19'h0, Mem_Ready}, 20'h0);
        Mem_Req = 1'b0;
        @(negedge Clk);
        Reset_ah = 1'b0;
        repeat (3) @(negedge Clk);

        // SRAM write, then read it back
        do_access(1'b1, 16'h0020, 16'h1234, 16'h0000, W + 1, W, 0, W - 1, W);
        check("sram_model_word", {4'h0, mem[8'h20]}, 20'h01234);
        do_access(1'b0, 16'h0020, 16'h0000, 16'h1234, W + 1, W, W, 0, 0);

        // I/O read of switches, then I/O write to hex display
        do_access(1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 1, 0, 0, 0, 0);
        do_access(1'b1, 16'hFFFF, 16'h0C3F, 16'h00A5, 1, 0, 0, 0, 0);
        check("hex_data", {4'h0, HEX_Data}, 20'h00C3F);
        check("mdr_in_after_io_wr", {4'h0, MDR_In}, 20'h000A5);

        // Mem_Req held across two reads; MAR moves during the first SRAM_RD
        @(negedge Clk);
        rc0 = ready_cnt;
        c0  = cyc;
        Mem_Req = 1'b1; Mem_WE = 1'b0; MAR = 16'h0010;
        exp_q.push_back(16'hBEEF);
        cyc_q.push_back(c0 + W + 1);
        exp_q.push_back(16'h5A5A);
        cyc_q.push_back(c0 + 2 * (W + 1) + 1);
        @(posedge Clk);
        #1;
        MAR = 16'h0030;
        for (int i = 0; i < 20 && (ready_cnt - rc0) < 2; i++) begin
            @(negedge Clk);
            #1;
        end
        Mem_Req = 1'b0;
        repeat (4) @(negedge Clk);
        check("held_req_ready_count", 20'(ready_cnt - rc0), 20'd2);

        check("queue_drained", 20'(exp_q.size()), 20'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish before 50000");
        $fatal(1, "bench timeout");
    end

endmodule
